alu_share_arbiter: RTL

Two-requester round-robin arbiter that time-shares the single combinational 32-bit ALU. It sits between two issue ports and the ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the result and returns it on the winning requester's response port, with write-enable and error qualification.

---
 rtl/alu_share_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that time-shares one combinational ALU
// between two requesters. One op in flight; IDLE -> EXEC -> RESP per op.
module alu_share_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid_0,
  output logic           req_ready_0,
  input  logic [OPW-1:0] req_op_0,
  input  logic [W-1:0]   req_a_0,
  input  logic [W-1:0]   req_b_0,
  output logic           rsp_valid_0,
  input  logic           rsp_ready_0,
  output logic [W-1:0]   rsp_result_0,
  output logic           rsp_zero_0,
  output logic           rsp_we_0,
  output logic           rsp_err_0,
  input  logic           req_valid_1,
  output logic           req_ready_1,
  input  logic [OPW-1:0] req_op_1,
  input  logic [W-1:0]   req_a_1,
  input  logic [W-1:0]   req_b_1,
  output logic           rsp_valid_1,
  input  logic           rsp_ready_1,
  output logic [W-1:0]   rsp_result_1,
  output logic           rsp_zero_1,
  output logic           rsp_we_1,
  output logic           rsp_err_1,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [W-1:0] result;
    logic         we;
    logic         err;
  } rsp_t;

  state_t         state, state_nxt;
  logic           last_grant;
  logic           gnt;
  logic           accept;
  logic           rsp_take;
  logic           win_p0;
  logic [OPW-1:0] op_p0;
  logic [W-1:0]   a_p0, b_p0;
  rsp_t           rsp_p1;
  logic [1:0]     rsp_valid_r, rsp_zero_r, rsp_we_r, rsp_err_r;
  logic [W-1:0]   rsp_result_r [2];

  localparam logic [OPW-1:0] OP_MOVN = OPW'(6'b001011);
  localparam logic [OPW-1:0] OP_MOVZ = OPW'(6'b001010);

  function automatic logic is_supported(input logic [OPW-1:0] op);
    case (op)
      OPW'(6'b001011), OPW'(6'b001010), OPW'(6'b100100), OPW'(6'b100101),
      OPW'(6'b100110), OPW'(6'b100111), OPW'(6'b100001), OPW'(6'b100011),
      OPW'(6'b100000), OPW'(6'b100010), OPW'(6'b000000), OPW'(6'b000100),
      OPW'(6'b000010), OPW'(6'b000110), OPW'(6'b101010), OPW'(6'b101011),
      OPW'(6'b000011), OPW'(6'b000111): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Qualify the ALU output: unsupported codes never forward the ALU, and a
  // suppressed conditional move returns operand a rather than the ALU value.
  function automatic rsp_t qualify(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] res);
    rsp_t r;
    r.result = res;
    r.we     = 1'b1;
    r.err    = 1'b0;
    if (!is_supported(op)) begin
      r.result = '0;
      r.we     = 1'b0;
      r.err    = 1'b1;
    end else if (op == OP_MOVN || op == OP_MOVZ) begin
      r.we = (op == OP_MOVN) ? (b != '0) : (b == '0);
      if (!r.we) r.result = a;
    end
    return r;
  endfunction

  // Grant selection and handshake qualification; ready only for the winner in IDLE.
  always_comb begin
    gnt         = (req_valid_0 && req_valid_1) ? ~last_grant : req_valid_1;
    req_ready_0 = (state == IDLE) && req_valid_0 && !gnt;
    req_ready_1 = (state == IDLE) && req_valid_1 && gnt;
    accept      = req_ready_0 || req_ready_1;
    rsp_take    = (state == RESP) && (win_p0 ? rsp_ready_1 : rsp_ready_0);
    rsp_p1      = qualify(op_p0, a_p0, b_p0, alu_result);
  end

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == EXEC) last_grant <= win_p0;
    end
  end

  // Stage p0: latch the accepted op; these registers drive the ALU directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      win_p0 <= 1'b0;
    end else if (accept) begin
      op_p0  <= gnt ? req_op_1 : req_op_0;
      a_p0   <= gnt ? req_a_1  : req_a_0;
      b_p0   <= gnt ? req_b_1  : req_b_0;
      win_p0 <= gnt;
    end
  end

  // Stage p1: capture the qualified result into the winner's response slot only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r     <= '0;
      rsp_zero_r      <= '0;
      rsp_we_r        <= '0;
      rsp_err_r       <= '0;
      rsp_result_r[0] <= '0;
      rsp_result_r[1] <= '0;
    end else if (state == EXEC) begin
      rsp_valid_r[win_p0]  <= 1'b1;
      rsp_result_r[win_p0] <= rsp_p1.result;
      rsp_zero_r[win_p0]   <= (rsp_p1.result == '0);
      rsp_we_r[win_p0]     <= rsp_p1.we;
      rsp_err_r[win_p0]    <= rsp_p1.err;
    end else if (rsp_take) begin
      rsp_valid_r[win_p0] <= 1'b0;
    end
  end

  assign alu_op       = op_p0;
  assign alu_a        = a_p0;
  assign alu_b        = b_p0;
  assign rsp_valid_0  = rsp_valid_r[0];
  assign rsp_valid_1  = rsp_valid_r[1];
  assign rsp_result_0 = rsp_result_r[0];
  assign rsp_result_1 = rsp_result_r[1];
  assign rsp_zero_0   = rsp_zero_r[0];
  assign rsp_zero_1   = rsp_zero_r[1];
  assign rsp_we_0     = rsp_we_r[0];
  assign rsp_we_1     = rsp_we_r[1];
  assign rsp_err_0    = rsp_err_r[0];
  assign rsp_err_1    = rsp_err_r[1];

endmodule
